// File: rtl/snitch_pma_pkg.sv
// Shared types and sizes for the runtime-programmable cached-region PMA table.
package snitch_pma_pkg;

   localparam int unsigned NrMaxRules = 4;   // hardware ceiling on cached-region rules
   localparam int unsigned PLEN       = 48;  // physical address width
   localparam int unsigned RuleIdxW   = 2;   // bits needed to index NrMaxRules rules
   localparam int unsigned RuleCntW   = 3;   // bits needed to hold a rule count 0..NrMaxRules

   // One region: an address hits when (addr & mask) == (base & mask).
   typedef struct packed {
      logic [PLEN-1:0] base;
      logic [PLEN-1:0] mask;
   } pma_rule_t;

   // Cached-region section of the PMA configuration.
   typedef struct packed {
      logic [RuleCntW-1:0]              NrCachedRegionRules;
      pma_rule_t [NrMaxRules-1:0]       CachedRegion;
   } snitch_pma_t;

endpackage

// File: rtl/snitch_pma_cfg.sv
// snitch_pma_cfg: software-programmable owner of the cached-region PMA table.
// A 32-bit register port edits a shadow copy; a COMMIT write copies the whole
// shadow table into the active table in one cycle. A pipelined lookup port
// answers "is this address cacheable" against the active table only.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   reg_valid_i/ready_o    register request handshake (ready = no commit pending)
//   reg_write_i            1 = write, 0 = read
//   reg_addr_i             word index
//   reg_wdata_i            write data
//   reg_rvalid_o           one-cycle response pulse per accepted request
//   reg_rdata_o            read data (0 for writes and errors)
//   reg_error_o            unmapped index, qualified by reg_rvalid_o
//   lk_valid_i/ready_o     lookup request handshake
//   lk_addr_i              lookup address
//   lk_rsp_valid_o/ready_i lookup response handshake
//   lk_rsp_cached_o        address hits an active rule
module snitch_pma_cfg
   import snitch_pma_pkg::*;
#(
   parameter int unsigned NrRules = 4,
   parameter snitch_pma_t PmaCfg  = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            reg_valid_i,
   output logic            reg_ready_o,
   input  logic            reg_write_i,
   input  logic [4:0]      reg_addr_i,
   input  logic [31:0]     reg_wdata_i,
   output logic            reg_rvalid_o,
   output logic [31:0]     reg_rdata_o,
   output logic            reg_error_o,
   input  logic            lk_valid_i,
   output logic            lk_ready_o,
   input  logic [PLEN-1:0] lk_addr_i,
   output logic            lk_rsp_valid_o,
   input  logic            lk_rsp_ready_i,
   output logic            lk_rsp_cached_o
);

   localparam int unsigned RegW   = 32;
   localparam int unsigned HiW    = PLEN - RegW;
   localparam int unsigned MatchW = 40;

   localparam logic [4:0] AddrNrRules = 5'd16;
   localparam logic [4:0] AddrCommit  = 5'd17;
   localparam logic [4:0] AddrStatus  = 5'd18;

   // Reset count is clipped to the number of implemented rules.
   localparam logic [RuleCntW-1:0] ResetCnt =
      (32'(PmaCfg.NrCachedRegionRules) > NrRules) ? RuleCntW'(NrRules)
                                                  : PmaCfg.NrCachedRegionRules;

   pma_rule_t [NrMaxRules-1:0] shadow_q, shadow_d, active_q;
   logic [RuleCntW-1:0]        shadow_cnt_q, shadow_cnt_d, active_cnt_q;
   logic                       pending_q, pending_d;
   logic                       rvalid_q, error_q, error_d;
   logic [RegW-1:0]            rdata_q, rdata_d;
   logic                       lk_rsp_valid_q, lk_rsp_cached_q;
   logic                       reg_acc, lk_acc, lk_hit;
   logic [RuleIdxW-1:0]        rule_idx;
   logic                       rule_ok;
   logic                       unused_lk;

   assign reg_acc     = reg_valid_i & ~pending_q;
   assign lk_ready_o  = ~pending_q & (~lk_rsp_valid_q | lk_rsp_ready_i);
   assign lk_acc      = lk_valid_i & lk_ready_o;
   assign reg_ready_o = ~pending_q;

   assign rule_idx = reg_addr_i[3:2];
   assign rule_ok  = 32'(rule_idx) < NrRules;

   // Register decode: shadow edits, read mux, error flag and commit request.
   always_comb begin
      shadow_d     = shadow_q;
      shadow_cnt_d = shadow_cnt_q;
      pending_d    = 1'b0;
      rdata_d      = '0;
      error_d      = 1'b0;
      if (reg_acc) begin
         if (!reg_addr_i[4]) begin
            if (!rule_ok) begin
               error_d = 1'b1;
            end else begin
               unique case (reg_addr_i[1:0])
                  2'd0: if (reg_write_i) shadow_d[rule_idx].base[RegW-1:0] = reg_wdata_i;
                        else rdata_d = shadow_q[rule_idx].base[RegW-1:0];
                  2'd1: if (reg_write_i) shadow_d[rule_idx].base[PLEN-1:RegW] = reg_wdata_i[HiW-1:0];
                        else rdata_d = RegW'(shadow_q[rule_idx].base[PLEN-1:RegW]);
                  2'd2: if (reg_write_i) shadow_d[rule_idx].mask[RegW-1:0] = reg_wdata_i;
                        else rdata_d = shadow_q[rule_idx].mask[RegW-1:0];
                  2'd3: if (reg_write_i) shadow_d[rule_idx].mask[PLEN-1:RegW] = reg_wdata_i[HiW-1:0];
                        else rdata_d = RegW'(shadow_q[rule_idx].mask[PLEN-1:RegW]);
                  default: ;
               endcase
            end
         end else begin
            unique case (reg_addr_i)
               AddrNrRules: begin
                  if (reg_write_i) begin
                     shadow_cnt_d = (reg_wdata_i > RegW'(NrRules)) ? RuleCntW'(NrRules)
                                                                   : RuleCntW'(reg_wdata_i);
                  end else begin
                     rdata_d = RegW'(shadow_cnt_q);
                  end
               end
               AddrCommit: if (reg_write_i && reg_wdata_i[0]) pending_d = 1'b1;
               AddrStatus: if (!reg_write_i) rdata_d = RegW'(pending_q);
               default:    error_d = 1'b1;
            endcase
         end
      end
   end

   // Active-table match; only bits [39:0] take part.
   always_comb begin
      lk_hit = 1'b0;
      for (int unsigned k = 0; k < NrRules; k++) begin
         if ((RuleCntW'(k) < active_cnt_q) &&
             (((lk_addr_i[MatchW-1:0] ^ active_q[RuleIdxW'(k)].base[MatchW-1:0]) &
               active_q[RuleIdxW'(k)].mask[MatchW-1:0]) == '0)) begin
            lk_hit = 1'b1;
         end
      end
   end

   assign unused_lk = ^{lk_addr_i[PLEN-1:MatchW], active_q};

   // Shadow table, commit and register response.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         shadow_q     <= PmaCfg.CachedRegion;
         shadow_cnt_q <= ResetCnt;
         active_q     <= PmaCfg.CachedRegion;
         active_cnt_q <= ResetCnt;
         pending_q    <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         error_q      <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         shadow_cnt_q <= shadow_cnt_d;
         pending_q    <= pending_d;
         rvalid_q     <= reg_acc;
         rdata_q      <= rdata_d;
         error_q      <= error_d;
         // No requests are accepted while pending, so the shadow is stable here.
         if (pending_q) begin
            active_q     <= shadow_q;
            active_cnt_q <= shadow_cnt_q;
         end
      end
   end

   // Lookup response stage; held until consumed.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lk_rsp_valid_q  <= 1'b0;
         lk_rsp_cached_q <= 1'b0;
      end else if (lk_acc) begin
         lk_rsp_valid_q  <= 1'b1;
         lk_rsp_cached_q <= lk_hit;
      end else if (lk_rsp_ready_i) begin
         lk_rsp_valid_q  <= 1'b0;
      end
   end

   assign reg_rvalid_o    = rvalid_q;
   assign reg_rdata_o     = rdata_q;
   assign reg_error_o     = error_q;
   assign lk_rsp_valid_o  = lk_rsp_valid_q;
   assign lk_rsp_cached_o = lk_rsp_cached_q;

endmodule
